// File: rtl/bp_trace_pkg.sv
// Trace packet layout and shared constants for the branch-trace delta encoder.
// The commit packet carries the PC in its low bits with opaque metadata above it.
package bp_trace_pkg;

  localparam int unsigned pkt_width_gp         = 64;
  localparam int unsigned count_width_gp       = 14;
  localparam int unsigned payload_width_gp     = 48;
  localparam int unsigned type_msb_gp          = 63;
  localparam int unsigned type_lsb_gp          = 62;
  localparam int unsigned count_msb_gp         = 61;
  localparam int unsigned count_lsb_gp         = 48;
  localparam int unsigned payload_msb_gp       = 47;
  localparam int unsigned ovf_bit_gp           = 47;
  localparam int unsigned RUN_MAX              = 16383;
  localparam int unsigned commit_meta_width_gp = 32;

  typedef enum logic [1:0] {
    trace_none_e  = 2'b00,
    trace_sync_e  = 2'b01,
    trace_delta_e = 2'b10,
    trace_run_e   = 2'b11
  } trace_type_e;

  typedef struct packed {
    trace_type_e                 typ;
    logic [count_width_gp-1:0]   count;
    logic [payload_width_gp-1:0] payload;
  } trace_pkt_s;

endpackage

// File: rtl/bp_trace_fifo.sv
// Shift-register FIFO: the head always lives in slot 0, so the output comes straight from a flop.
module bp_trace_fifo #(
  parameter int unsigned width = 64,
  parameter int unsigned els   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic [width-1:0] enq_data,
  input  logic             deq,
  output logic [width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned cnt_w_lp = $clog2(els + 1);
  localparam int unsigned idx_w_lp = $clog2(els);

  logic [width-1:0]    mem [els];
  logic [cnt_w_lp-1:0] cnt;
  logic [cnt_w_lp-1:0] cnt_nxt;
  logic [cnt_w_lp-1:0] wr_slot;
  logic                do_enq;
  logic                do_deq;

  assign do_enq  = enq & ~full;
  assign do_deq  = deq & ~empty;
  assign wr_slot = do_deq ? cnt - cnt_w_lp'(1) : cnt;
  assign cnt_nxt = cnt + cnt_w_lp'(do_enq) - cnt_w_lp'(do_deq);
  assign head    = mem[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      for (int i = 0; i < els; i++) mem[i] <= '0;
    end else begin
      if (do_deq) begin
        for (int i = 0; i < els - 1; i++) mem[i] <= mem[i+1];
      end
      // Write after the shift so a simultaneous pop lands the new entry one slot lower.
      if (do_enq) mem[idx_w_lp'(wr_slot)] <= enq_data;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == cnt_w_lp'(els));
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/bp_trace_delta_encoder.sv
// Branch-trace delta encoder: compresses committed PCs into SYNC / DELTA / RUN packets
// and queues them for a consumer, dropping (and flagging overflow) when the queue is full.
module bp_trace_delta_encoder
  import bp_trace_pkg::*;
#(
  parameter  int unsigned trace_width_p             = 64,
  parameter  int unsigned pc_width_p                = 40,
  parameter  int unsigned fifo_els_p                = 4,
  parameter  int unsigned sync_period_p             = 256,
  localparam int unsigned bp_be_commit_pkt_width_lp = commit_meta_width_gp + pc_width_p
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 trace_en_i,
  input  logic [bp_be_commit_pkt_width_lp-1:0] commit_pkt_i,
  input  logic                                 commit_v_i,
  input  logic                                 commit_ready_i,
  output logic [trace_width_p-1:0]             trace_data_o,
  output logic                                 trace_v_o,
  input  logic                                 trace_ready_i,
  output logic                                 trace_drop_o
);

  localparam int unsigned sync_cnt_w_lp = $clog2(sync_period_p) + 1;

  logic [pc_width_p-1:0]     pc;
  logic [pc_width_p-1:0]     delta;
  logic [pc_width_p-1:0]     last_pc, last_pc_nxt;
  logic [count_width_gp-1:0] run_cnt, run_nxt, run_inc;
  logic [sync_cnt_w_lp-1:0]  sync_cnt, sync_nxt;
  logic                      need_sync, need_nxt;
  logic                      ovf_r, ovf_nxt;
  logic                      fire, seq, force_sync;
  logic                      emit, is_sync, drop;
  logic                      fifo_full, fifo_empty;
  trace_pkt_s                pkt;
  trace_pkt_s                head;
  logic                      unused_meta;

  assign unused_meta = ^commit_pkt_i[bp_be_commit_pkt_width_lp-1:pc_width_p];

  assign pc         = commit_pkt_i[pc_width_p-1:0];
  assign fire       = commit_v_i & commit_ready_i & trace_en_i;
  assign seq        = (pc == last_pc + pc_width_p'(4));
  assign force_sync = need_sync | (sync_cnt == sync_cnt_w_lp'(sync_period_p - 1));
  assign delta      = pc - last_pc;
  assign run_inc    = run_cnt + count_width_gp'(1);

  // Packet selection and tracking-state update for one commit.
  always_comb begin
    pkt         = '0;
    emit        = 1'b0;
    is_sync     = 1'b0;
    last_pc_nxt = last_pc;
    run_nxt     = run_cnt;
    sync_nxt    = sync_cnt;
    need_nxt    = need_sync | ~trace_en_i;
    ovf_nxt     = ovf_r;
    if (fire) begin
      last_pc_nxt = pc;
      if (force_sync) begin
        emit        = 1'b1;
        is_sync     = 1'b1;
        pkt.typ     = trace_sync_e;
        pkt.count   = run_cnt;
        pkt.payload = {ovf_r, ovf_bit_gp'(pc)};
        sync_nxt    = '0;
        need_nxt    = 1'b0;
      end else begin
        sync_nxt = sync_cnt + sync_cnt_w_lp'(1);
        if (!seq) begin
          emit        = 1'b1;
          pkt.typ     = trace_delta_e;
          pkt.count   = run_cnt;
          pkt.payload = {{(payload_width_gp - pc_width_p){delta[pc_width_p-1]}}, delta};
        end else if (run_inc == count_width_gp'(RUN_MAX)) begin
          emit      = 1'b1;
          pkt.typ   = trace_run_e;
          pkt.count = count_width_gp'(RUN_MAX);
        end else begin
          run_nxt = run_inc;
        end
      end
      if (emit) begin
        run_nxt = '0;
        // A lost packet breaks the decoder's PC chain, so the next packet must resynchronise.
        if (fifo_full) begin
          need_nxt = 1'b1;
          ovf_nxt  = 1'b1;
        end else if (is_sync) begin
          ovf_nxt = 1'b0;
        end
      end
    end
  end

  assign drop = emit & fifo_full;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_pc      <= '0;
      run_cnt      <= '0;
      sync_cnt     <= '0;
      need_sync    <= 1'b1;
      ovf_r        <= 1'b0;
      trace_drop_o <= 1'b0;
    end else begin
      last_pc      <= last_pc_nxt;
      run_cnt      <= run_nxt;
      sync_cnt     <= sync_nxt;
      need_sync    <= need_nxt;
      ovf_r        <= ovf_nxt;
      trace_drop_o <= drop;
    end
  end

  bp_trace_fifo #(
    .width(pkt_width_gp),
    .els  (fifo_els_p)
  ) fifo (
    .clk     (clk_i),
    .rst     (reset_i),
    .enq     (emit & ~fifo_full),
    .enq_data(pkt),
    .deq     (trace_ready_i),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign trace_v_o = ~fifo_empty;

  always_comb begin
    trace_data_o                              = '0;
    trace_data_o[type_msb_gp:type_lsb_gp]     = head.typ;
    trace_data_o[count_msb_gp:count_lsb_gp]   = head.count;
    trace_data_o[payload_msb_gp:0]            = head.payload;
  end

endmodule

// File: tb/tb_bp_trace_delta_encoder.sv
// Bench for bp_trace_delta_encoder: two instances (short and long sync period) share stimulus
// and are compared each cycle against a packet-level reference model.
module tb_bp_trace_delta_encoder;
  import bp_trace_pkg::*;

  localparam int unsigned cpw = commit_meta_width_gp + 40;
  localparam longint two39 = 64'sh80_0000_0000;
  localparam longint two40 = 64'sh100_0000_0000;

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic           trace_en = 1'b1;
  logic [cpw-1:0] commit_pkt = '0;
  logic           commit_v = 1'b0;
  logic           commit_ready = 1'b0;
  logic           trace_ready = 1'b0;
  logic [63:0]    data_a;
  logic [71:0]    data_b;
  logic           v_a, v_b, drop_a, drop_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one set per instance.
  int          per [2] = '{4, 20000};
  logic [39:0] m_last [2];
  int          m_run  [2];
  int          m_scnt [2];
  bit          m_need [2];
  bit          m_ovf  [2];
  bit          m_drop [2];
  logic [63:0] m_q    [2][4];
  int          m_cnt  [2];

  bp_trace_delta_encoder #(.trace_width_p(64), .pc_width_p(40), .fifo_els_p(4), .sync_period_p(4)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .trace_en_i(trace_en), .commit_pkt_i(commit_pkt),
    .commit_v_i(commit_v), .commit_ready_i(commit_ready), .trace_data_o(data_a),
    .trace_v_o(v_a), .trace_ready_i(trace_ready), .trace_drop_o(drop_a));

  bp_trace_delta_encoder #(.trace_width_p(72), .pc_width_p(40), .fifo_els_p(4), .sync_period_p(20000)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .trace_en_i(trace_en), .commit_pkt_i(commit_pkt),
    .commit_v_i(commit_v), .commit_ready_i(commit_ready), .trace_data_o(data_b),
    .trace_v_o(v_b), .trace_ready_i(trace_ready), .trace_drop_o(drop_b));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  function automatic logic [71:0] obs_data(input int k);
    return (k == 0) ? 72'(data_a) : data_b;
  endfunction
  function automatic logic obs_v(input int k);
    return (k == 0) ? v_a : v_b;
  endfunction
  function automatic logic obs_drop(input int k);
    return (k == 0) ? drop_a : drop_b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = '0; m_run[k] = 0; m_scnt[k] = 0; m_need[k] = 1'b1;
      m_ovf[k] = 1'b0; m_drop[k] = 1'b0; m_cnt[k] = 0;
      for (int j = 0; j < 4; j++) m_q[k][j] = '0;
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input bit v, input bit cr, input bit en, input bit rdy, input logic [39:0] pc);
    for (int k = 0; k < 2; k++) begin
      bit full, deq, emit, sync;
      logic [63:0] pkt;
      longint d;
      full = (m_cnt[k] == 4);
      deq  = (m_cnt[k] > 0) && rdy;
      emit = 1'b0; sync = 1'b0; pkt = '0; m_drop[k] = 1'b0;
      if (v && cr && en) begin
        if (m_need[k] || m_scnt[k] == per[k] - 1) begin
          sync = 1'b1; emit = 1'b1;
          pkt = {2'b01, 14'(m_run[k]), m_ovf[k], 7'd0, pc};
        end else begin
          m_scnt[k]++;
          d = longint'(pc) - longint'(m_last[k]);
          if (d < 0) d += two40;
          if (d != 4) begin
            if (d >= two39) d -= two40;
            emit = 1'b1;
            pkt = {2'b10, 14'(m_run[k]), d[47:0]};
          end else begin
            m_run[k]++;
            if (m_run[k] == RUN_MAX) begin
              emit = 1'b1;
              pkt = {2'b11, 14'd16383, 48'd0};
            end
          end
        end
        m_last[k] = pc;
        if (sync) begin m_scnt[k] = 0; m_need[k] = 1'b0; end
        if (emit) begin
          m_run[k] = 0;
          if (full) begin m_drop[k] = 1'b1; m_ovf[k] = 1'b1; m_need[k] = 1'b1; end
          else if (sync) m_ovf[k] = 1'b0;
        end
      end
      if (!en) m_need[k] = 1'b1;
      if (deq) begin
        for (int j = 0; j < 3; j++) m_q[k][j] = m_q[k][j+1];
        m_cnt[k]--;
      end
      if (emit && !full) begin
        m_q[k][m_cnt[k]] = pkt;
        m_cnt[k]++;
      end
    end
  endtask

  task automatic cyc(input bit v, input bit cr, input bit en, input bit rdy, input logic [39:0] pc);
    @(negedge clk);
    commit_v = v; commit_ready = cr; trace_en = en; trace_ready = rdy;
    commit_pkt = {commit_meta_width_gp'($urandom), pc};
    model_edge(v, cr, en, rdy, pc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1; commit_v = 1'b0; trace_ready = 1'b0; trace_en = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({v_a, v_b} !== 2'b00) begin
      n_errors++; $display("FAIL reset_valid: v_a=%b v_b=%b required 0 0", v_a, v_b);
    end
    n_checks++;
    if ({drop_a, drop_b} !== 2'b00) begin
      n_errors++; $display("FAIL reset_drop: drop_a=%b drop_b=%b required 0 0", drop_a, drop_b);
    end
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
  endtask

  task automatic test_first_sync();
    do_reset();
    cyc(1, 1, 1, 0, 40'h80000000);
    n_checks++;
    if (v_b !== 1'b1 || data_b !== 72'h00_4000_0000_8000_0000) begin
      n_errors++; $display("FAIL first_sync: v=%b data=%h required 1 004000000080000000", v_b, data_b);
    end
    n_checks++;
    if (data_a[47] !== 1'b0) begin
      n_errors++; $display("FAIL first_sync_ovf: bit47=%b required 0", data_a[47]);
    end
  endtask

  task automatic test_delta();
    logic [39:0] pcs [4] = '{40'h1000, 40'h1004, 40'h1008, 40'h2000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1, 1, pcs[i]);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_v(k) !== (m_cnt[k] != 0) || obs_drop(k) !== m_drop[k] ||
            (m_cnt[k] != 0 && obs_data(k) !== 72'(m_q[k][0]))) begin
          n_errors++;
          $display("FAIL delta dut%0d step%0d: v=%b drop=%b data=%h required v=%b drop=%b data=%h",
                   k, i, obs_v(k), obs_drop(k), obs_data(k), m_cnt[k] != 0, m_drop[k], 72'(m_q[k][0]));
        end
      end
    end
    n_checks++;
    if (v_b !== 1'b1 || data_b !== 72'h00_8002_0000_0000_0FF8) begin
      n_errors++; $display("FAIL delta_const: v=%b data=%h required 1 008002000000000ff8", v_b, data_b);
    end
  endtask

  task automatic test_backward();
    do_reset();
    cyc(1, 1, 1, 1, 40'h2000);
    cyc(1, 1, 1, 1, 40'h1000);
    n_checks++;
    if (v_b !== 1'b1 || data_b !== 72'h00_8000_FFFF_FFFF_F000) begin
      n_errors++; $display("FAIL backward: v=%b data=%h required 1 008000fffffffff000", v_b, data_b);
    end
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 5)      cyc(1, 1, 1, 0, 40'h3000 + 40'(i * 'h40));
      else if (i < 6) cyc(0, 1, 1, 0, 40'h0);
      else            cyc(0, 1, 1, 1, 40'h0);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_v(k) !== (m_cnt[k] != 0) || obs_drop(k) !== m_drop[k] ||
            (m_cnt[k] != 0 && obs_data(k) !== 72'(m_q[k][0]))) begin
          n_errors++;
          $display("FAIL drop dut%0d step%0d: v=%b drop=%b data=%h required v=%b drop=%b data=%h",
                   k, i, obs_v(k), obs_drop(k), obs_data(k), m_cnt[k] != 0, m_drop[k], 72'(m_q[k][0]));
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({drop_a, drop_b} !== 2'b11) begin
          n_errors++; $display("FAIL drop_pulse: drop_a=%b drop_b=%b required 1 1", drop_a, drop_b);
        end
      end
      if (i == 5) begin
        n_checks++;
        if ({drop_a, drop_b, v_a, v_b} !== 4'b0011) begin
          n_errors++; $display("FAIL drop_single: drop=%b%b v=%b%b required 00 11", drop_a, drop_b, v_a, v_b);
        end
      end
    end
    cyc(1, 1, 1, 0, 40'h5000);
    n_checks++;
    if ({data_a[63:62], data_a[47], data_b[63:62], data_b[47]} !== 6'b01_1_01_1) begin
      n_errors++;
      $display("FAIL drop_resync: a=%h b=%h required SYNC with bit47=1 on both", data_a, data_b);
    end
  endtask

  task automatic test_sync_period();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 1, 1, 40'h4000 + 40'(i * 'h100));
      n_checks++;
      if (v_a !== 1'b1 || data_a[63:62] !== ((i % 4 == 0) ? 2'b01 : 2'b10)) begin
        n_errors++;
        $display("FAIL period fire%0d: v=%b type=%b required 1 %b", i + 1, v_a, data_a[63:62],
                 (i % 4 == 0) ? 2'b01 : 2'b10);
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_v(k) !== (m_cnt[k] != 0) || obs_drop(k) !== m_drop[k] ||
            (m_cnt[k] != 0 && obs_data(k) !== 72'(m_q[k][0]))) begin
          n_errors++;
          $display("FAIL period dut%0d step%0d: v=%b data=%h required v=%b data=%h",
                   k, i, obs_v(k), obs_data(k), m_cnt[k] != 0, 72'(m_q[k][0]));
        end
      end
    end
  endtask

  task automatic test_run_limit();
    int runs_seen = 0;
    logic [13:0] run_count_seen = '0;
    do_reset();
    cyc(1, 1, 1, 1, 40'h10000);
    for (int i = 0; i < 16384; i++) begin
      cyc(1, 1, 1, 1, 40'h10004 + 40'(i * 4));
      if (v_b === 1'b1 && data_b[63:62] === 2'b11) begin
        runs_seen++;
        run_count_seen = data_b[61:48];
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_v(k) !== (m_cnt[k] != 0) || obs_drop(k) !== m_drop[k] ||
            (m_cnt[k] != 0 && obs_data(k) !== 72'(m_q[k][0]))) begin
          n_errors++;
          $display("FAIL run dut%0d step%0d: v=%b data=%h required v=%b data=%h",
                   k, i, obs_v(k), obs_data(k), m_cnt[k] != 0, 72'(m_q[k][0]));
        end
      end
    end
    n_checks++;
    if (runs_seen != 1 || run_count_seen !== 14'd16383) begin
      n_errors++; $display("FAIL run_once: runs=%0d count=%0d required 1 16383", runs_seen, run_count_seen);
    end
    cyc(1, 1, 1, 1, 40'h900000);
    n_checks++;
    if (v_b !== 1'b1 || data_b[63:48] !== 16'h8001) begin
      n_errors++; $display("FAIL run_after: v=%b type_count=%h required 1 8001", v_b, data_b[63:48]);
    end
    cyc(1, 1, 0, 1, 40'h900004);
    cyc(1, 1, 1, 1, 40'h900100);
    n_checks++;
    if (v_b !== 1'b1 || data_b[63:62] !== 2'b01) begin
      n_errors++; $display("FAIL enable_resync: v=%b type=%b required 1 01", v_b, data_b[63:62]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 40'h7000 + 40'(i * 'h80));
    #2;
    reset_i = 1'b1;
    #1;
    n_checks++;
    if ({v_a, v_b, drop_a, drop_b} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_mid: v=%b%b drop=%b%b required 00 00", v_a, v_b, drop_a, drop_b);
    end
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
    cyc(1, 1, 1, 0, 40'h7400);
    n_checks++;
    if ({v_a, data_a[63:62], data_a[47], v_b, data_b[63:62], data_b[47]} !== 8'b1_01_0_1_01_0) begin
      n_errors++; $display("FAIL reset_mid_sync: a=%h b=%h required SYNC with bit47=0", data_a, data_b);
    end
  endtask

  task automatic test_random();
    logic [39:0] pc = 40'h1000;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(9))
        0, 1, 2, 3, 4: pc = pc + 40'd4;
        5:             pc = 40'hFF_FFFF_FFF0 + 40'($urandom_range(3) * 4);
        default:       pc = {8'($urandom), 32'($urandom)};
      endcase
      cyc($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(15) != 0,
          $urandom_range(2) != 0, pc);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_v(k) !== (m_cnt[k] != 0) || obs_drop(k) !== m_drop[k] ||
            (m_cnt[k] != 0 && obs_data(k) !== 72'(m_q[k][0]))) begin
          n_errors++;
          $display("FAIL random dut%0d step%0d: v=%b drop=%b data=%h required v=%b drop=%b data=%h",
                   k, i, obs_v(k), obs_drop(k), obs_data(k), m_cnt[k] != 0, m_drop[k], 72'(m_q[k][0]));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_sync();
    test_delta();
    test_backward();
    test_drop();
    test_sync_period();
    test_run_limit();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
